reg_xfer_datapath: RTL and testbench

Parametrised, self-sequencing successor to the single-bus CPU datapath. It holds a register file of NREGS×W registers plus Y, Z (2W), HI and LO. It accepts one register-transfer command at a time over a valid/ready handshake and drives the internal bus through its own T-state sequence. The sequence is Rb→Y, then ALU(Y, Rc)→Z, then Z→Ra or Z→HI/LO. Multiply and signed division write HI/LO; division is an iterative multi-cycle operation.

---
 rtl/reg_xfer_pkg.sv | 33 +++
 rtl/seq_divider.sv | 67 ++++++
 rtl/reg_xfer_datapath.sv | 153 +++++++++++++++
 tb/tb_reg_xfer_datapath.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_xfer_pkg.sv
// Shared types for the register-transfer datapath: opcodes, sequencer states
// and opcode classification helpers.
package reg_xfer_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_SHRA = 4'd6,
    OP_NEG  = 4'd7,
    OP_NOT  = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIV  = 4'd10,
    OP_LDI  = 4'd11,
    OP_MFHI = 4'd12,
    OP_MFLO = 4'd13
  } op_e;

  typedef enum logic [2:0] {IDLE, TY, TZ, TDIV, TWB, THILO} state_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= 4'd14;
  endfunction

  // Commands that go straight from IDLE to the write-back state.
  function automatic logic is_short(input logic [3:0] op);
    return is_illegal(op) || op == OP_LDI || op == OP_MFHI || op == OP_MFLO;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring signed divider: one quotient bit per cycle on operand magnitudes,
// signs applied at the output. Quotient truncates toward zero.
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div0
);

  localparam int CW = $clog2(W + 1);

  logic          r_busy, r_qneg, r_rneg, r_div0;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rem, r_quo, r_dvs, r_dvd;
  logic [W:0]    w_shift, w_trial;
  logic          w_ge;

  // Partial remainder stays below the divisor magnitude, so W+1 bits suffice.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_trial[W];

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_busy <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_div0 <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_dvd  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(W);
      r_rem  <= '0;
      r_quo  <= dividend[W-1] ? -dividend : dividend;
      r_dvs  <= divisor[W-1] ? -divisor : divisor;
      r_dvd  <= dividend;
      r_qneg <= dividend[W-1] ^ divisor[W-1];
      r_rneg <= dividend[W-1];
      r_div0 <= (divisor == '0);
    end else if (r_busy) begin
      r_rem <= w_ge ? w_trial[W-1:0] : w_shift[W-1:0];
      r_quo <= {r_quo[W-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign busy      = r_busy;
  assign done      = r_busy && (r_cnt == CW'(1));
  assign div0      = r_div0;
  assign quotient  = r_div0 ? '1 : (r_qneg ? -r_quo : r_quo);
  assign remainder = r_div0 ? r_dvd : (r_rneg ? -r_rem : r_rem);

endmodule

// File: rtl/reg_xfer_datapath.sv
// Self-sequencing single-bus datapath: register file, Y/Z/HI/LO, and a
// T-state sequencer executing one handshaked register-transfer command.
module reg_xfer_datapath
  import reg_xfer_pkg::*;
#(
  parameter int W     = 32,
  parameter int NREGS = 16,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [RW-1:0] cmd_ra,
  input  logic [RW-1:0] cmd_rb,
  input  logic [RW-1:0] cmd_rc,
  input  logic [W-1:0]  cmd_imm,
  output logic          done,
  output logic          err,
  input  logic [RW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [W-1:0]  hi,
  output logic [W-1:0]  lo
);

  localparam int SHW = $clog2(W);

  state_e          r_state, w_next;
  logic [3:0]      r_op;
  logic [RW-1:0]   r_ra, r_rb, r_rc;
  logic [W-1:0]    r_imm, r_y, r_hi, r_lo;
  logic [2*W-1:0]  r_z;
  logic [W-1:0]    r_rf [NREGS];
  logic            w_div_start, w_div_busy, w_div_done, w_div0;
  logic [W-1:0]    w_quo, w_rem;

  function automatic logic [2*W-1:0] alu(input logic [3:0] op,
                                         input logic [W-1:0] y,
                                         input logic [W-1:0] c);
    logic [W-1:0]   res;
    logic [SHW-1:0] sh;
    logic [2*W-1:0] ys, cs;
    sh  = c[SHW-1:0];
    ys  = {{W{y[W-1]}}, y};
    cs  = {{W{c[W-1]}}, c};
    res = '0;
    case (op)
      OP_ADD:  res = y + c;
      OP_SUB:  res = y - c;
      OP_AND:  res = y & c;
      OP_OR:   res = y | c;
      OP_SHL:  res = y << sh;
      OP_SHR:  res = y >> sh;
      OP_SHRA: res = $signed(y) >>> sh;
      OP_NEG:  res = -y;
      OP_NOT:  res = ~y;
      default: res = '0;
    endcase
    // Sign-extended operands make the low 2W bits of the product the signed result.
    if (op == OP_MUL) return ys * cs;
    return {{W{1'b0}}, res};
  endfunction

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: next state gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid && cmd_ready) w_next = is_short(cmd_op) ? TWB : TY;
      TY:      w_next = (r_op == OP_DIV) ? TDIV : TZ;
      TZ:      w_next = (r_op == OP_MUL) ? THILO : TWB;
      TDIV:    if (w_div_done) w_next = THILO;
      default: w_next = IDLE;
    endcase
  end

  assign cmd_ready   = (r_state == IDLE) && !w_div_busy;
  assign done        = (r_state == TWB) || (r_state == THILO);
  assign err         = ((r_state == TWB) && is_illegal(r_op)) ||
                       ((r_state == THILO) && (r_op == OP_DIV) && w_div0);
  assign w_div_start = (r_state == TY) && (r_op == OP_DIV);

  // NOTE: the register file is reset with everything else because clear must
  // leave no architectural state behind.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      r_op  <= '0;
      r_ra  <= '0;
      r_rb  <= '0;
      r_rc  <= '0;
      r_imm <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        r_op  <= cmd_op;
        r_ra  <= cmd_ra;
        r_rb  <= cmd_rb;
        r_rc  <= cmd_rc;
        r_imm <= cmd_imm;
      end
      case (r_state)
        TY: r_y <= r_rf[r_rb];
        TZ: r_z <= alu(r_op, r_y, r_rf[r_rc]);
        TWB: begin
          case (r_op)
            OP_LDI:  r_rf[r_ra] <= r_imm;
            OP_MFHI: r_rf[r_ra] <= r_hi;
            OP_MFLO: r_rf[r_ra] <= r_lo;
            default: if (!is_illegal(r_op)) r_rf[r_ra] <= r_z[W-1:0];
          endcase
        end
        THILO: begin
          if (r_op == OP_MUL) begin
            r_hi <= r_z[2*W-1:W];
            r_lo <= r_z[W-1:0];
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  // The divider reads Rc alongside Rb; nothing writes the file before commit.
  seq_divider #(.W(W)) u_div (
    .clock     (clock),
    .clear     (clear),
    .start     (w_div_start),
    .dividend  (r_rf[r_rb]),
    .divisor   (r_rf[r_rc]),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem),
    .div0      (w_div0)
  );

  assign rd_data = r_rf[rd_addr];
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_reg_xfer_datapath.sv
// Directed and random command stream against an arithmetic reference model
// of the register-transfer datapath (W=32, 16 registers).
module tb_reg_xfer_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_ra, cmd_rb, cmd_rc;
  logic [31:0] cmd_imm;
  logic        done, err;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data, hi, lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_rf [16];
  logic [31:0] m_hi, m_lo;

  reg_xfer_datapath dut (
    .clock     (clock),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ra    (cmd_ra),
    .cmd_rb    (cmd_rb),
    .cmd_rc    (cmd_rc),
    .cmd_imm   (cmd_imm),
    .done      (done),
    .err       (err),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_hi = '0;
    m_lo = '0;
  endtask

  // Reference semantics; also returns expected latency and error flag.
  task automatic model_apply(input logic [3:0] op, input int ra, input int rb, input int rc,
                             input logic [31:0] imm, output int lat, output bit e);
    logic [31:0] a, b;
    longint      sa, sb, q, r;
    logic [63:0] p;
    a   = m_rf[rb];
    b   = m_rf[rc];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    e   = 1'b0;
    lat = 3;
    case (op)
      4'd0:  m_rf[ra] = a + b;
      4'd1:  m_rf[ra] = a - b;
      4'd2:  m_rf[ra] = a & b;
      4'd3:  m_rf[ra] = a | b;
      4'd4:  m_rf[ra] = a << b[4:0];
      4'd5:  m_rf[ra] = a >> b[4:0];
      4'd6:  m_rf[ra] = $signed(a) >>> b[4:0];
      4'd7:  m_rf[ra] = -a;
      4'd8:  m_rf[ra] = ~a;
      4'd9: begin
        p = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      4'd10: begin
        lat = 34;
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
          e = 1'b1;
        end else begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      4'd11: begin m_rf[ra] = imm;  lat = 1; end
      4'd12: begin m_rf[ra] = m_hi; lat = 1; end
      4'd13: begin m_rf[ra] = m_lo; lat = 1; end
      default: begin lat = 1; e = 1'b1; end
    endcase
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), rd_data, m_rf[i]);
    end
  endtask

  // Issue one command, scramble the fields after acceptance, and check
  // latency, err, ready/done behaviour and the resulting state.
  task automatic do_cmd(input string tag, input logic [3:0] op, input int ra,
                        input int rb, input int rc, input logic [31:0] imm);
    int lat, cyc;
    bit e, got, got_err;
    model_apply(op, ra, rb, rc, imm, lat, e);
    @(negedge clock);
    check({tag, "_ready_idle"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_ra = 4'(ra);
    cmd_rb = 4'(rb);
    cmd_rc = 4'(rc);
    cmd_imm = imm;
    cyc = 0;
    got = 1'b0;
    got_err = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom);
        cmd_ra = 4'($urandom);
        cmd_rb = 4'($urandom);
        cmd_rc = 4'($urandom);
        cmd_imm = $urandom;
      end
      check({tag, "_ready_busy"}, cmd_ready, 1'b0);
      if (done) begin
        got = 1'b1;
        got_err = err;
      end
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_err"}, got_err, e);
    @(negedge clock);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_ready_after"}, cmd_ready, 1'b1);
    rd_addr = 4'(ra);
    #1;
    check({tag, "_rd"}, rd_data, m_rf[ra]);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    int cyc, lat;
    bit e;
    clear = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_ra = '0;
    cmd_rb = '0;
    cmd_rc = '0;
    cmd_imm = '0;
    rd_addr = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_rd", rd_data, 32'h0);
    clear = 1'b0;

    do_cmd("ldi_r1", 4'd11, 1, 0, 0, 32'd5);
    do_cmd("ldi_r2", 4'd11, 2, 0, 0, 32'd7);
    do_cmd("add", 4'd0, 3, 1, 2, 32'h0);
    check("add_value", m_rf[3], 32'd12);

    do_cmd("ldi_zero", 4'd11, 1, 0, 0, 32'h0);
    do_cmd("ldi_one", 4'd11, 2, 0, 0, 32'h1);
    do_cmd("sub_wrap", 4'd1, 3, 1, 2, 32'h0);
    do_cmd("ldi_msb", 4'd11, 1, 0, 0, 32'h8000_0000);
    do_cmd("ldi_sh4", 4'd11, 2, 0, 0, 32'd4);
    do_cmd("shra", 4'd6, 3, 1, 2, 32'h0);
    do_cmd("shr", 4'd5, 10, 1, 2, 32'h0);
    do_cmd("and", 4'd2, 11, 1, 3, 32'h0);
    do_cmd("neg", 4'd7, 12, 2, 9, 32'h0);
    do_cmd("not", 4'd8, 13, 1, 5, 32'h0);
    do_cmd("alias_add", 4'd0, 2, 2, 2, 32'h0);

    do_cmd("ldi_m3", 4'd11, 4, 0, 0, 32'hFFFF_FFFD);
    do_cmd("ldi_big", 4'd11, 5, 0, 0, 32'h4000_0000);
    do_cmd("mul", 4'd9, 0, 4, 5, 32'h0);
    do_cmd("mfhi", 4'd12, 14, 0, 0, 32'h0);
    do_cmd("mflo", 4'd13, 15, 0, 0, 32'h0);

    do_cmd("ldi_m7", 4'd11, 6, 0, 0, 32'hFFFF_FFF9);
    do_cmd("ldi_two", 4'd11, 7, 0, 0, 32'd2);
    do_cmd("div", 4'd10, 0, 6, 7, 32'h0);
    do_cmd("div_zero", 4'd10, 0, 6, 0, 32'h0);
    do_cmd("illegal15", 4'd15, 3, 1, 2, 32'h0);
    check_all("illegal_state");

    // MUL with cmd_valid held high: an LDI queued behind it must be taken
    // in the first cycle after done.
    model_apply(4'd9, 0, 1, 2, 32'h0, lat, e);
    model_apply(4'd11, 9, 0, 0, 32'h0000_1234, lat, e);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 4'd9;
    cmd_ra = 4'd0;
    cmd_rb = 4'd1;
    cmd_rc = 4'd2;
    for (cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clock);
      check($sformatf("hold_done_c%0d", cyc), done, (cyc == 3 || cyc == 5));
      check($sformatf("hold_ready_c%0d", cyc), cmd_ready, (cyc == 4));
      if (cyc == 3) begin
        cmd_op = 4'd11;
        cmd_ra = 4'd9;
        cmd_imm = 32'h0000_1234;
      end
      if (cyc == 5) cmd_valid = 1'b0;
    end
    @(negedge clock);
    rd_addr = 4'd9;
    #1;
    check("hold_rd", rd_data, m_rf[9]);
    check("hold_hi", hi, m_hi);
    check("hold_lo", lo, m_lo);

    // Clear in cycle 10 of a DIV wipes everything immediately.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 4'd10;
    cmd_rb = 4'd6;
    cmd_rc = 4'd7;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clock);
    clear = 1'b1;
    rd_addr = 4'd6;
    #1;
    check("clr_hi", hi, 32'h0);
    check("clr_lo", lo, 32'h0);
    check("clr_rd", rd_data, 32'h0);
    check("clr_ready", cmd_ready, 1'b1);
    check("clr_done", done, 1'b0);
    check("clr_err", err, 1'b0);
    @(negedge clock);
    clear = 1'b0;
    model_reset();
    check_all("clr_state");
    do_cmd("ldi_after_clr", 4'd11, 8, 0, 0, 32'h0000_00A5);
    repeat (40) @(negedge clock);
    check("clr_no_late_done", done, 1'b0);
    check_all("clr_no_late_write");

    for (int n = 0; n < 60; n++) begin
      do_cmd($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $urandom);
    end
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
